// File: rtl/frame_buf_sched.sv
// frame_buf_sched: triple-buffer frame bank scheduler; the bank being written is never the bank being read
module frame_buf_sched #(
  parameter int ADDR_W = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 28'h0000000,
  parameter logic [ADDR_W-1:0] FRAME_SIZE = 28'h0200000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr_frame_start,
  input  logic              wr_frame_done,
  input  logic              rd_frame_start,
  output logic [1:0]        wr_bank,
  output logic [1:0]        rd_bank,
  output logic [ADDR_W-1:0] wr_base,
  output logic [ADDR_W-1:0] rd_base,
  output logic              wr_busy,
  output logic              rd_new_frame,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       repeat_cnt
);
  typedef enum logic {IDLE, WRITING} state_t;
  state_t state_q, state_d;
  logic [1:0] wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, lat_q, lat_d;
  logic lat_v_q, lat_v_d, rd_new_q, rd_new_d;
  logic [15:0] drop_q, drop_d, rep_q, rep_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d, rd_base_q, rd_base_d;
  logic done, start, drop_inc, rep_inc, busy0, busy1;
  function automatic logic [ADDR_W-1:0] base(input logic [1:0] b);
    return b == 2'd0 ? BASE_ADDR : b == 2'd1 ? BASE_ADDR + FRAME_SIZE : BASE_ADDR + FRAME_SIZE + FRAME_SIZE;
  endfunction
  always_comb begin
    done = state_q == WRITING && wr_frame_done;
    start = state_q == IDLE && wr_frame_start && en;
    // a completion coinciding with a read start hands the fresh bank straight to the reader
    rd_bank_d = !rd_frame_start ? rd_bank_q : done ? wr_bank_q : lat_v_q ? lat_q : rd_bank_q;
    rd_new_d = rd_frame_start && (done || lat_v_q);
    rep_inc = rd_frame_start && !done && !lat_v_q;
    lat_d = done ? wr_bank_q : lat_q;
    lat_v_d = rd_new_d ? 1'b0 : done ? 1'b1 : lat_v_q;
    drop_inc = (done && lat_v_q) || (state_q == WRITING && wr_frame_start && !wr_frame_done);
    state_d = start ? WRITING : done ? IDLE : state_q;
    // new write bank avoids the post-read reader bank and any still-pending latest frame
    busy0 = rd_bank_d == 2'd0 || (lat_v_d && lat_d == 2'd0);
    busy1 = rd_bank_d == 2'd1 || (lat_v_d && lat_d == 2'd1);
    wr_bank_d = !start ? wr_bank_q : !busy0 ? 2'd0 : !busy1 ? 2'd1 : 2'd2;
    drop_d = drop_q + 16'(drop_inc && drop_q != 16'hFFFF);
    rep_d = rep_q + 16'(rep_inc && rep_q != 16'hFFFF);
    wr_base_d = base(wr_bank_d);
    rd_base_d = base(rd_bank_d);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_bank_q <= 2'd1;
      rd_bank_q <= 2'd0;
      lat_q <= 2'd0;
      lat_v_q <= 1'b0;
      rd_new_q <= 1'b0;
      drop_q <= '0;
      rep_q <= '0;
      wr_base_q <= base(2'd1);
      rd_base_q <= base(2'd0);
    end else begin
      state_q <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      lat_q <= lat_d;
      lat_v_q <= lat_v_d;
      rd_new_q <= rd_new_d;
      drop_q <= drop_d;
      rep_q <= rep_d;
      wr_base_q <= wr_base_d;
      rd_base_q <= rd_base_d;
    end
  end
  assign wr_bank = wr_bank_q;
  assign rd_bank = rd_bank_q;
  assign wr_base = wr_base_q;
  assign rd_base = rd_base_q;
  assign wr_busy = state_q == WRITING;
  assign rd_new_frame = rd_new_q;
  assign drop_cnt = drop_q;
  assign repeat_cnt = rep_q;
endmodule
